// File: rtl/msu_data_prefetch_if.sv
// HPS-side fetch bus for the MSU-1 data prefetcher.
// Handshake: the master holds mem_req high with a stable mem_addr until the slave pulses mem_ack
// for exactly one cycle with mem_data valid; mem_ack while mem_req is low is ignored.
interface msu_data_prefetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/msu_data_prefetch.sv
// MSU-1 $2001 data port sequencer: seeks restart a byte stream fetched from the HPS side
// into a small circular prefetch FIFO that serves SNES reads at bus speed.
module msu_data_prefetch #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  seek_req,
    input  logic [31:0]           seek_addr,
    input  logic                  rd_pop,
    output logic [7:0]            rd_data,
    output logic                  data_busy,
    output logic [31:0]           cur_addr,
    output logic                  underrun,
    msu_data_prefetch_if.master   mem,
    output logic [1:0]            dbg_state,
    output logic [DEPTH_LOG2:0]   dbg_count
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [31:0]           fetch_addr;
    logic [31:0]           pend_addr;
    logic [31:0]           new_addr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [7:0]            fifo_mem [0:(1<<DEPTH_LOG2)-1];
    logic                  active;
    logic                  flush;
    logic                  push;
    logic                  pop;
    logic                  latch_pend;
    logic                  has_room;

    assign has_room = (count != FULL);
    // A seek in the same cycle swallows the pop entirely (no pop, no underrun).
    assign pop      = rd_pop && !seek_req && (count != '0);

    always_comb begin
        state_nxt  = state;
        flush      = 1'b0;
        push       = 1'b0;
        latch_pend = 1'b0;
        new_addr   = seek_addr;
        case (state)
            S_IDLE: begin
                if (seek_req) begin
                    flush     = 1'b1;
                    state_nxt = S_FETCH;
                end else if (active && has_room) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem.mem_ack) begin
                    flush     = seek_req;
                    push      = !seek_req;
                    state_nxt = S_GAP;
                end else if (seek_req) begin
                    latch_pend = 1'b1;
                    state_nxt  = S_DRAIN;
                end
            end
            S_GAP: begin
                if (seek_req) begin
                    flush     = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = has_room ? S_FETCH : S_IDLE;
                end
            end
            S_DRAIN: begin
                // The outstanding byte belongs to the old stream and is dropped.
                if (mem.mem_ack) begin
                    flush     = 1'b1;
                    new_addr  = seek_req ? seek_addr : pend_addr;
                    state_nxt = S_GAP;
                end else if (seek_req) begin
                    latch_pend = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            active     <= 1'b0;
            fetch_addr <= '0;
            pend_addr  <= '0;
            cur_addr   <= '0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_busy  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state    <= state_nxt;
            underrun <= rd_pop && !seek_req && (count == '0);
            if (seek_req) begin
                active <= 1'b1;
            end
            if (latch_pend) begin
                pend_addr <= seek_addr;
            end
            if (seek_req) begin
                data_busy <= 1'b1;
            end else if (push) begin
                data_busy <= 1'b0;
            end
            if (flush) begin
                fetch_addr <= new_addr;
                cur_addr   <= new_addr;
                count      <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
            end else begin
                if (push) begin
                    fetch_addr <= fetch_addr + 32'd1;
                    wr_ptr     <= wr_ptr + DEPTH_LOG2'(1);
                end
                if (pop) begin
                    cur_addr <= cur_addr + 32'd1;
                    rd_ptr   <= rd_ptr + DEPTH_LOG2'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem.mem_data;
        end
    end

    assign rd_data      = (count != '0) ? fifo_mem[rd_ptr] : 8'h00;
    assign mem.mem_req  = (state == S_FETCH) || (state == S_DRAIN);
    assign mem.mem_addr = fetch_addr;
    assign dbg_state    = state;
    assign dbg_count    = count;
endmodule

// File: doc/msu_data_prefetch.md
# msu_data_prefetch

Sequencing controller for the MSU-1 data port ($2001). It accepts seek commands from the MSU register block and fetches bytes from the HPS-side data source over a request/acknowledge handshake. Fetched bytes go into a small prefetch FIFO, so SNES reads of $2001 are served at bus speed. It also drives the MSU_STATUS data-busy bit and the current data address.

## Interface
- DEPTH_LOG2, 3, FIFO depth = 2^DEPTH_LOG2 bytes (minimum 1)
- CLK  in  1  system clock; all logic on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- seek_req  in  1  one-cycle pulse: restart stream at seek_addr (from $2003 write)
- seek_addr  in  32  byte address, sampled only when seek_req=1
- rd_pop  in  1  one-cycle pulse: SNES finished reading $2001 (RD_N rising edge)
- rd_data  out  8  FIFO head byte; 0 when FIFO empty
- data_busy  out  1  MSU_STATUS bit 7; high while the post-seek stream is not yet ready
- cur_addr  out  32  address of byte presented on rd_data
- underrun  out  1  one-cycle pulse: rd_pop arrived with FIFO empty
- mem_req  out  1  fetch request to HPS side
- mem_addr  out  32  fetch byte address; stable while mem_req=1
- mem_ack  in  1  one-cycle pulse: mem_data valid, request complete
- mem_data  in  8  fetched byte, valid only with mem_ack

## Operation
- State register: IDLE, FETCH, GAP, DRAIN. Internal state: fetch_addr (32b), FIFO count (DEPTH_LOG2+1 bits), pend_seek flag, pend_addr (32b).
- IDLE: no stream active (after reset) or FIFO full. On seek_req, or when the stream is active and count < DEPTH, go to FETCH with mem_req=1 and mem_addr=fetch_addr.
- FETCH: mem_req held at 1. On mem_ack: push mem_data, fetch_addr += 1, go to GAP.
- GAP: one cycle with mem_req=0. Then go to FETCH if count < DEPTH, otherwise IDLE.
- Seek while in FETCH (request outstanding):
  - Go to DRAIN and latch pend_addr.
  - Keep mem_req=1 until mem_ack. Discard that byte.
  - Then flush the FIFO, set fetch_addr = pend_addr, and go to GAP.
- Seek in IDLE or GAP: flush the FIFO immediately; fetch_addr = cur_addr = seek_addr.
- Seek in DRAIN: overwrite pend_addr. Last seek wins.
- data_busy:
  - Set by seek_req.
  - Cleared in the cycle after the first post-seek byte is pushed.
  - Not re-asserted by later FIFO underflow.
- rd_pop with count > 0: pop head, cur_addr += 1.
- rd_pop with count = 0: ignored; cur_addr unchanged; underrun pulse.
- Simultaneous events:
  - seek_req + rd_pop: seek wins; pop ignored, no underrun.
  - mem_ack + rd_pop in FETCH: push and pop both apply; count unchanged.
  - mem_ack + seek_req: the byte is discarded; the new seek applies.
- Address arithmetic is modulo 2^32; 32'hFFFFFFFF increments to 0.
- FIFO is a circular buffer; read and write pointers wrap at DEPTH.

## Timing
- Reset (async assert, sync release) values:
  - state=IDLE, mem_req=0, mem_addr=0, rd_data=0
  - data_busy=0, cur_addr=0, underrun=0, count=0, stream inactive
- No fetch occurs before the first seek_req.
- seek_req at cycle T (from IDLE or GAP): data_busy=1 and count=0 at T+1; mem_req=1 with mem_addr=seek_addr at T+1.
- mem_ack at A: byte on rd_data at A+1 if the FIFO was empty; data_busy=0 at A+1 for the first post-seek byte; mem_req=0 at A+1; next mem_req no earlier than A+2.
- rd_pop at P: next byte (or 0) on rd_data at P+1; cur_addr updated at P+1; underrun high for cycle P+1 only.
- mem_req never drops before mem_ack. mem_addr never changes while mem_req=1.
- mem_ack while mem_req=0 is ignored.
- Full FIFO: no mem_req until a pop frees space. Re-request issues the cycle after count < DEPTH.

## Test plan
- Reset mid-FETCH (mem_req=1) -> all outputs at reset values the next cycle; a late mem_ack is ignored; no request until the next seek.
- seek 0x00001000, ack every request after 3 cycles, no pops -> mem_addr sequence 0x1000..0x1007, FIFO full, mem_req idle; data_busy low 1 cycle after the first ack; rd_data = first byte.
- Full FIFO, 8 pops -> bytes in order; cur_addr ends 0x1008; one pop leaves count 7 and mem_req rises with mem_addr 0x1008.
- seek 0x2000 then seek 0x5000 while the 0x2000 request is outstanding -> DRAIN until ack; byte discarded; next mem_addr=0x5000; rd_data is the 0x5000 byte; data_busy falls only after that byte arrives.
- seek 0xFFFFFFFE, 3 fetches and 3 pops -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; cur_addr ends 0x00000001.
- Pop on empty FIFO -> underrun one cycle, cur_addr unchanged. Same-cycle seek+pop -> pop ignored, no underrun, cur_addr = seek address.
